// File: rtl/ccip_if_pkg.sv
// CCI-P channel structures shared by the sub-AFU quiesce logic and its bench.
// Only the header fields this lab uses are modelled; payload widths match CCI-P.
package ccip_if_pkg;

   localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
   localparam logic [3:0] eREQ_RDLINE_S = 4'h1;
   localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
   localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
   localparam logic [3:0] eREQ_WRPUSH_I = 4'h2;
   localparam logic [3:0] eREQ_WRFENCE  = 4'h4;
   localparam logic [3:0] eREQ_INTR     = 4'h6;

   localparam logic [3:0] eRSP_RDLINE   = 4'h0;
   localparam logic [3:0] eRSP_UMSG     = 4'h4;
   localparam logic [3:0] eRSP_WRLINE   = 4'h0;
   localparam logic [3:0] eRSP_WRFENCE  = 4'h4;
   localparam logic [3:0] eRSP_INTR     = 4'h6;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic        sop;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      logic [8:0]  tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic [63:0]         data;
      logic                mmioRdValid;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        hit_miss;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        hit_miss;
      logic        format;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      logic [511:0]       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

endpackage

// File: rtl/vai_afu_drain.sv
// Per-sub-AFU quiesce stage: counts in-flight read lines and write lines/fences,
// and on a manager drain request holds the sub-AFU in reset, gates its traffic,
// and reports completion once every outstanding response has come back.
module vai_afu_drain
   import ccip_if_pkg::*;
#(
   parameter int CNT_W          = 10,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             pClk,
   input  logic             SoftReset,
   input  logic             drain_req,
   input  t_if_ccip_Tx      afu_TxPort,
   output t_if_ccip_Rx      afu_RxPort,
   output t_if_ccip_Tx      dn_TxPort,
   input  t_if_ccip_Rx      dn_RxPort,
   output logic             afu_SoftReset,
   output logic             drain_done,
   output logic             drain_timeout,
   output logic             cnt_err,
   output logic [CNT_W-1:0] rd_outstanding,
   output logic [CNT_W-1:0] wr_outstanding
);

   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drainState_t;

   drainState_t      state;
   logic [TO_W-1:0]  toCnt;
   logic             runMode;
   logic             isWrLine;
   logic [2:0]       rdInc;
   logic [2:0]       rdDec;
   logic [2:0]       wrInc;
   logic [2:0]       wrDec;
   logic [CNT_W:0]   rdUpd;
   logic [CNT_W:0]   wrUpd;
   logic [CNT_W-1:0] rdNext;
   logic [CNT_W-1:0] wrNext;
   logic             rdErr;
   logic             wrErr;

   // Applies one cycle's net increment/decrement, clamping at both ends; the
   // top bit of the result flags that a clamp was needed.
   function automatic logic [CNT_W:0] netUpdate(
      input logic [CNT_W-1:0] cur,
      input logic [2:0]       inc,
      input logic [2:0]       dec
   );
      logic [CNT_W+1:0] sum;
      sum = {2'b00, cur} + (CNT_W+2)'(inc);
      if ((CNT_W+2)'(dec) > sum) begin
         return {1'b1, {CNT_W{1'b0}}};
      end
      sum = sum - (CNT_W+2)'(dec);
      if (sum > {2'b00, CNT_MAX}) begin
         return {1'b1, CNT_MAX};
      end
      return {1'b0, sum[CNT_W-1:0]};
   endfunction

   // Work out how many lines each channel adds and retires this cycle.
   // Requests only count while they are allowed through (RUN); responses count
   // in every state so that late arrivals after a drain are flagged.
   always_comb begin
      runMode  = (state == RUN);
      isWrLine = (afu_TxPort.c1.hdr.req_type == eREQ_WRLINE_I) ||
                 (afu_TxPort.c1.hdr.req_type == eREQ_WRLINE_M) ||
                 (afu_TxPort.c1.hdr.req_type == eREQ_WRPUSH_I);
      rdInc    = 3'd0;
      rdDec    = 3'd0;
      wrInc    = 3'd0;
      wrDec    = 3'd0;
      if (runMode && afu_TxPort.c0.valid) begin
         rdInc = {1'b0, afu_TxPort.c0.hdr.cl_len} + 3'd1;
      end
      if (runMode && afu_TxPort.c1.valid) begin
         if (afu_TxPort.c1.hdr.req_type == eREQ_WRFENCE) begin
            wrInc = 3'd1;
         end else if (isWrLine && afu_TxPort.c1.hdr.sop) begin
            wrInc = {1'b0, afu_TxPort.c1.hdr.cl_len} + 3'd1;
         end
      end
      if (dn_RxPort.c0.rspValid && (dn_RxPort.c0.hdr.resp_type == eRSP_RDLINE)) begin
         rdDec = 3'd1;
      end
      if (dn_RxPort.c1.rspValid) begin
         if (dn_RxPort.c1.hdr.resp_type == eRSP_WRFENCE) begin
            wrDec = 3'd1;
         end else if (dn_RxPort.c1.hdr.resp_type == eRSP_WRLINE) begin
            wrDec = dn_RxPort.c1.hdr.format ? ({1'b0, dn_RxPort.c1.hdr.cl_num} + 3'd1) : 3'd1;
         end
      end
      rdUpd  = netUpdate(rd_outstanding, rdInc, rdDec);
      wrUpd  = netUpdate(wr_outstanding, wrInc, wrDec);
      rdNext = rdUpd[CNT_W-1:0];
      wrNext = wrUpd[CNT_W-1:0];
      rdErr  = rdUpd[CNT_W];
      wrErr  = wrUpd[CNT_W];
   end

   // Registered pass-through in both directions; only the request and response
   // valids are suppressed outside RUN, so MMIO and almost-full keep flowing.
   always_ff @(posedge pClk) begin
      if (SoftReset) begin
         dn_TxPort  <= '0;
         afu_RxPort <= '0;
      end else begin
         dn_TxPort             <= afu_TxPort;
         dn_TxPort.c0.valid    <= afu_TxPort.c0.valid && runMode;
         dn_TxPort.c1.valid    <= afu_TxPort.c1.valid && runMode;
         afu_RxPort            <= dn_RxPort;
         afu_RxPort.c0.rspValid <= dn_RxPort.c0.rspValid && runMode;
         afu_RxPort.c1.rspValid <= dn_RxPort.c1.rspValid && runMode;
      end
   end

   // Drain sequencer: RUN -> DRAIN on request, DRAIN -> DONE once both counts
   // settle at zero (or the timeout expires), DONE -> RUN once the request drops.
   // Entering DRAIN clears the sticky flags, but an error detected in that same
   // cycle still survives the clear.
   always_ff @(posedge pClk) begin
      if (SoftReset) begin
         state          <= RUN;
         toCnt          <= '0;
         afu_SoftReset  <= 1'b1;
         drain_done     <= 1'b0;
         drain_timeout  <= 1'b0;
         cnt_err        <= 1'b0;
         rd_outstanding <= '0;
         wr_outstanding <= '0;
      end else begin
         rd_outstanding <= rdNext;
         wr_outstanding <= wrNext;
         if (rdErr || wrErr) begin
            cnt_err <= 1'b1;
         end
         case (state)
            RUN: begin
               drain_done <= 1'b0;
               if (drain_req) begin
                  state         <= DRAIN;
                  toCnt         <= '0;
                  afu_SoftReset <= 1'b1;
                  drain_timeout <= 1'b0;
                  cnt_err       <= rdErr || wrErr;
               end else begin
                  afu_SoftReset <= 1'b0;
               end
            end
            DRAIN: begin
               afu_SoftReset <= 1'b1;
               if ((rdNext == '0) && (wrNext == '0)) begin
                  state      <= DONE;
                  drain_done <= 1'b1;
               end else if (toCnt == TO_LAST) begin
                  state          <= DONE;
                  drain_done     <= 1'b1;
                  drain_timeout  <= 1'b1;
                  rd_outstanding <= '0;
                  wr_outstanding <= '0;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            DONE: begin
               if (!drain_req) begin
                  state         <= RUN;
                  afu_SoftReset <= 1'b0;
                  drain_done    <= 1'b0;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vai_afu_drain.sv
// Bench for the sub-AFU quiesce stage: directed drain scenarios followed by a
// randomized stretch, every cycle compared against a transaction-level model.
module tb_vai_afu_drain;
   import ccip_if_pkg::*;

   localparam int CNT_W   = 6;
   localparam int TO_CYC  = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef enum int {M_RUN, M_DRAIN, M_DONE} modelMode_t;

   logic             pClk;
   logic             SoftReset;
   logic             drain_req;
   t_if_ccip_Tx      afuTx;
   t_if_ccip_Rx      afu_RxPort;
   t_if_ccip_Tx      dn_TxPort;
   t_if_ccip_Rx      dnRx;
   logic             afu_SoftReset;
   logic             drain_done;
   logic             drain_timeout;
   logic             cnt_err;
   logic [CNT_W-1:0] rd_outstanding;
   logic [CNT_W-1:0] wr_outstanding;

   int checks   = 0;
   int failures = 0;

   modelMode_t mMode;
   int         mRd, mWr, mElapsed;
   logic       mAfuRst, mDone, mTimeout, mErr;

   vai_afu_drain #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .pClk           (pClk),
      .SoftReset      (SoftReset),
      .drain_req      (drain_req),
      .afu_TxPort     (afuTx),
      .afu_RxPort     (afu_RxPort),
      .dn_TxPort      (dn_TxPort),
      .dn_RxPort      (dnRx),
      .afu_SoftReset  (afu_SoftReset),
      .drain_done     (drain_done),
      .drain_timeout  (drain_timeout),
      .cnt_err        (cnt_err),
      .rd_outstanding (rd_outstanding),
      .wr_outstanding (wr_outstanding)
   );

   // Free-running clock.
   initial begin
      pClk = 1'b0;
      forever #5 pClk = ~pClk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      afuTx = '0;
      dnRx  = '0;
   endtask

   // Predict the effect of the currently driven inputs from the drain rules,
   // advance one clock, then compare every observable against the prediction.
   task automatic applyStimulus();
      int         rdDelta, wrDelta, newRd, newWr;
      bit         passing, errNow;
      logic       expTx0, expTx1, expRx0, expRx1, expMmio, expAf;
      logic [15:0] expTxMd, expRxMd;
      passing = (mMode == M_RUN);
      rdDelta = 0;
      wrDelta = 0;
      errNow  = 0;
      if (passing && afuTx.c0.valid) rdDelta += int'(afuTx.c0.hdr.cl_len) + 1;
      if (passing && afuTx.c1.valid) begin
         if (afuTx.c1.hdr.req_type == eREQ_WRFENCE) wrDelta += 1;
         else if (afuTx.c1.hdr.sop) wrDelta += int'(afuTx.c1.hdr.cl_len) + 1;
      end
      if (dnRx.c0.rspValid && dnRx.c0.hdr.resp_type == eRSP_RDLINE) rdDelta -= 1;
      if (dnRx.c1.rspValid) begin
         if (dnRx.c1.hdr.resp_type == eRSP_WRFENCE) wrDelta -= 1;
         else if (dnRx.c1.hdr.resp_type == eRSP_WRLINE)
            wrDelta -= dnRx.c1.hdr.format ? int'(dnRx.c1.hdr.cl_num) + 1 : 1;
      end
      newRd = mRd + rdDelta;
      newWr = mWr + wrDelta;
      if (newRd < 0)       begin newRd = 0;       errNow = 1; end
      if (newRd > CNT_MAX) begin newRd = CNT_MAX; errNow = 1; end
      if (newWr < 0)       begin newWr = 0;       errNow = 1; end
      if (newWr > CNT_MAX) begin newWr = CNT_MAX; errNow = 1; end

      expTx0  = SoftReset ? 1'b0 : (afuTx.c0.valid & passing);
      expTx1  = SoftReset ? 1'b0 : (afuTx.c1.valid & passing);
      expRx0  = SoftReset ? 1'b0 : (dnRx.c0.rspValid & passing);
      expRx1  = SoftReset ? 1'b0 : (dnRx.c1.rspValid & passing);
      expMmio = SoftReset ? 1'b0 : afuTx.c2.mmioRdValid;
      expAf   = SoftReset ? 1'b0 : dnRx.c0TxAlmFull;
      expTxMd = SoftReset ? 16'h0 : afuTx.c0.hdr.mdata;
      expRxMd = SoftReset ? 16'h0 : dnRx.c0.hdr.mdata;

      if (SoftReset) begin
         mMode = M_RUN; mRd = 0; mWr = 0; mElapsed = 0;
         mAfuRst = 1; mDone = 0; mTimeout = 0; mErr = 0;
      end else begin
         mRd = newRd;
         mWr = newWr;
         if (errNow) mErr = 1;
         case (mMode)
            M_RUN: begin
               mDone = 0;
               if (drain_req) begin
                  mMode = M_DRAIN; mElapsed = 0; mAfuRst = 1;
                  mTimeout = 0; mErr = errNow;
               end else begin
                  mAfuRst = 0;
               end
            end
            M_DRAIN: begin
               if (mRd == 0 && mWr == 0) begin
                  mMode = M_DONE; mDone = 1;
               end else if (mElapsed + 1 == TO_CYC) begin
                  mMode = M_DONE; mDone = 1; mTimeout = 1; mRd = 0; mWr = 0;
               end else begin
                  mElapsed++;
               end
            end
            default: begin
               if (!drain_req) begin
                  mMode = M_RUN; mAfuRst = 0; mDone = 0;
               end
            end
         endcase
      end

      @(posedge pClk);
      #1;
      checkOutput("afuSoftReset", afu_SoftReset, mAfuRst);
      checkOutput("drainDone", drain_done, mDone);
      checkOutput("drainTimeout", drain_timeout, mTimeout);
      checkOutput("cntErr", cnt_err, mErr);
      checkOutput("rdOutstanding", rd_outstanding, mRd);
      checkOutput("wrOutstanding", wr_outstanding, mWr);
      checkOutput("dnTxC0Valid", dn_TxPort.c0.valid, expTx0);
      checkOutput("dnTxC1Valid", dn_TxPort.c1.valid, expTx1);
      checkOutput("afuRxC0Valid", afu_RxPort.c0.rspValid, expRx0);
      checkOutput("afuRxC1Valid", afu_RxPort.c1.rspValid, expRx1);
      checkOutput("dnTxC2Mmio", dn_TxPort.c2.mmioRdValid, expMmio);
      checkOutput("afuRxAlmFull", afu_RxPort.c0TxAlmFull, expAf);
      checkOutput("dnTxC0Mdata", dn_TxPort.c0.hdr.mdata, expTxMd);
      checkOutput("afuRxC0Mdata", afu_RxPort.c0.hdr.mdata, expRxMd);
   endtask

   task automatic setRead(input logic [1:0] len, input logic [15:0] md);
      afuTx.c0.valid         = 1'b1;
      afuTx.c0.hdr.req_type  = eREQ_RDLINE_I;
      afuTx.c0.hdr.cl_len    = len;
      afuTx.c0.hdr.mdata     = md;
   endtask

   task automatic setWrite(input logic sop, input logic [1:0] len);
      afuTx.c1.valid         = 1'b1;
      afuTx.c1.hdr.req_type  = eREQ_WRLINE_I;
      afuTx.c1.hdr.sop       = sop;
      afuTx.c1.hdr.cl_len    = len;
   endtask

   task automatic setFence();
      afuTx.c1.valid         = 1'b1;
      afuTx.c1.hdr.req_type  = eREQ_WRFENCE;
   endtask

   task automatic setRdRsp(input logic [15:0] md);
      dnRx.c0.rspValid       = 1'b1;
      dnRx.c0.hdr.resp_type  = eRSP_RDLINE;
      dnRx.c0.hdr.mdata      = md;
   endtask

   task automatic setWrRsp(input logic [3:0] kind, input logic fmt, input logic [1:0] num);
      dnRx.c1.rspValid       = 1'b1;
      dnRx.c1.hdr.resp_type  = kind;
      dnRx.c1.hdr.format     = fmt;
      dnRx.c1.hdr.cl_num     = num;
   endtask

   // Directed scenarios followed by a randomized run.
   initial begin
      int doneAt;
      int pick;
      mMode = M_RUN; mRd = 0; mWr = 0; mElapsed = 0;
      mAfuRst = 1; mDone = 0; mTimeout = 0; mErr = 0;
      SoftReset = 1'b1;
      drain_req = 1'b0;
      clearInputs();
      applyStimulus();
      applyStimulus();
      checkOutput("rstAfuSoftReset", afu_SoftReset, 1);
      checkOutput("rstDrainDone", drain_done, 0);
      checkOutput("rstRd", rd_outstanding, 0);

      SoftReset = 1'b0;
      applyStimulus();
      checkOutput("relAfuSoftReset", afu_SoftReset, 0);

      $display("[TB] read of four lines then four responses");
      setRead(2'd3, 16'h1234);
      applyStimulus();
      checkOutput("p1Rd4", rd_outstanding, 4);
      checkOutput("p1TxMdata", dn_TxPort.c0.hdr.mdata, 16'h1234);
      clearInputs();
      for (int i = 0; i < 4; i++) begin
         setRdRsp(16'h0100 + 16'(i));
         applyStimulus();
         checkOutput("p1RspFwd", afu_RxPort.c0.rspValid, 1);
         checkOutput("p1RspMdata", afu_RxPort.c0.hdr.mdata, 16'h0100 + 64'(i));
      end
      clearInputs();
      checkOutput("p1Rd0", rd_outstanding, 0);

      $display("[TB] writes and fence then drain");
      setWrite(1'b1, 2'd0); applyStimulus();
      setWrite(1'b1, 2'd0); applyStimulus();
      clearInputs(); setFence(); applyStimulus();
      clearInputs();
      checkOutput("p2Wr3", wr_outstanding, 3);
      drain_req = 1'b1;
      applyStimulus();
      checkOutput("p2AfuRst", afu_SoftReset, 1);
      setWrRsp(eRSP_WRLINE, 1'b1, 2'd1);
      applyStimulus();
      checkOutput("p2Wr1", wr_outstanding, 1);
      checkOutput("p2NoFwd", afu_RxPort.c1.rspValid, 0);
      clearInputs(); setWrRsp(eRSP_WRFENCE, 1'b0, 2'd0);
      applyStimulus();
      checkOutput("p2Done", drain_done, 1);
      checkOutput("p2NoFwdFence", afu_RxPort.c1.rspValid, 0);
      clearInputs();
      drain_req = 1'b0;
      applyStimulus();
      checkOutput("p2BackToRun", afu_SoftReset, 0);

      $display("[TB] drain raised alongside a two-line read");
      drain_req = 1'b1;
      setRead(2'd1, 16'h0abc);
      applyStimulus();
      checkOutput("p3TxFwd", dn_TxPort.c0.valid, 1);
      checkOutput("p3Rd2", rd_outstanding, 2);
      drain_req = 1'b0;
      applyStimulus();
      checkOutput("p3TxBlocked", dn_TxPort.c0.valid, 0);
      checkOutput("p3Rd2Hold", rd_outstanding, 2);
      clearInputs(); setRdRsp(16'h0001);
      applyStimulus();
      checkOutput("p3NotDone", drain_done, 0);
      applyStimulus();
      checkOutput("p3Done", drain_done, 1);
      clearInputs();
      applyStimulus();
      checkOutput("p3Release", afu_SoftReset, 0);

      $display("[TB] simultaneous write and write response");
      setWrite(1'b1, 2'd0); applyStimulus();
      setWrRsp(eRSP_WRLINE, 1'b0, 2'd0);
      applyStimulus();
      checkOutput("p4WrStays1", wr_outstanding, 1);
      clearInputs(); setWrRsp(eRSP_WRLINE, 1'b0, 2'd0);
      applyStimulus();
      checkOutput("p4ErrClear", cnt_err, 0);
      applyStimulus();
      checkOutput("p4ErrSet", cnt_err, 1);
      checkOutput("p4WrZero", wr_outstanding, 0);

      $display("[TB] drain with a read that never returns");
      clearInputs(); setRead(2'd0, 16'h0055); applyStimulus();
      clearInputs();
      drain_req = 1'b1;
      applyStimulus();
      checkOutput("p5ErrCleared", cnt_err, 0);
      doneAt = 0;
      for (int i = 1; i <= 24; i++) begin
         applyStimulus();
         if (drain_done) begin
            doneAt = i;
            break;
         end
      end
      checkOutput("p5DoneCycle", doneAt, TO_CYC);
      checkOutput("p5Timeout", drain_timeout, 1);
      checkOutput("p5RdCleared", rd_outstanding, 0);
      setRdRsp(16'h0055);
      applyStimulus();
      checkOutput("p5LateErr", cnt_err, 1);
      checkOutput("p5LateDropped", afu_RxPort.c0.rspValid, 0);
      clearInputs();
      drain_req = 1'b0;
      applyStimulus();

      $display("[TB] reset while draining");
      setRead(2'd3, 16'h0002); applyStimulus();
      clearInputs(); setRead(2'd0, 16'h0003); applyStimulus();
      clearInputs();
      checkOutput("p6Rd5", rd_outstanding, 5);
      drain_req = 1'b1;
      applyStimulus();
      SoftReset = 1'b1;
      setRead(2'd0, 16'h0004);
      applyStimulus();
      checkOutput("p6RdZero", rd_outstanding, 0);
      checkOutput("p6AfuRst", afu_SoftReset, 1);
      checkOutput("p6TxValid", dn_TxPort.c0.valid, 0);
      SoftReset = 1'b0;
      drain_req = 1'b0;
      clearInputs();
      applyStimulus();
      checkOutput("p6Run", afu_SoftReset, 0);

      $display("[TB] read counter saturation");
      for (int i = 0; i < 16; i++) begin
         setRead(2'd3, 16'(i));
         applyStimulus();
      end
      clearInputs();
      checkOutput("satRdMax", rd_outstanding, CNT_MAX);
      checkOutput("satErr", cnt_err, 1);
      SoftReset = 1'b1;
      applyStimulus();
      SoftReset = 1'b0;
      applyStimulus();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 600; n++) begin
         clearInputs();
         if ($urandom_range(0, 2) == 0) setRead(2'($urandom_range(0, 3)), 16'($urandom));
         pick = $urandom_range(0, 5);
         if (pick == 0) setWrite(1'b1, 2'($urandom_range(0, 3)));
         else if (pick == 1) setWrite(1'b0, 2'($urandom_range(0, 3)));
         else if (pick == 2) setFence();
         if ($urandom_range(0, 2) == 0) begin
            setRdRsp(16'($urandom));
            if ($urandom_range(0, 3) == 0) dnRx.c0.hdr.resp_type = eRSP_UMSG;
         end
         pick = $urandom_range(0, 8);
         if (pick == 0) setWrRsp(eRSP_WRLINE, 1'b0, 2'd0);
         else if (pick == 1) setWrRsp(eRSP_WRLINE, 1'b1, 2'($urandom_range(0, 3)));
         else if (pick == 2) setWrRsp(eRSP_WRFENCE, 1'b0, 2'd0);
         else if (pick == 3) setWrRsp(eRSP_INTR, 1'b0, 2'd0);
         afuTx.c2.mmioRdValid = 1'($urandom_range(0, 1));
         dnRx.c0TxAlmFull     = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
         SoftReset = ($urandom_range(0, 149) == 0);
         applyStimulus();
      end
      SoftReset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vai_afu_drain.md
Name: vai_afu_drain

Overview:
- Per-sub-AFU quiesce stage. One instance per sub-AFU, between the sub-AFU's CCI-P ports and the per-AFU Tx/Rx audit stages that feed the nested mux.
- Tracks outstanding c0 read lines and c1 write lines/fences for its sub-AFU.
- On a manager reset request it holds the sub-AFU in reset and gates its Tx. It signals drain_done only after every in-flight response has returned, so the AFU slot can be reassigned cleanly.

Parameters:
- CNT_W, 10, width of the outstanding read and write counters.
- TIMEOUT_CYCLES, 4096, maximum DRAIN duration before forced completion.

Ports:
- pClk  in  1  clock.
- SoftReset  in  1  synchronous, active-high reset.
- drain_req  in  1  level from the vai_mgr sub_afu_reset bit for this AFU.
- afu_TxPort  in  t_if_ccip_Tx  requests from the sub-AFU.
- afu_RxPort  out  t_if_ccip_Rx  responses to the sub-AFU.
- dn_TxPort  out  t_if_ccip_Tx  requests toward the Tx audit.
- dn_RxPort  in  t_if_ccip_Rx  responses from the Rx audit.
- afu_SoftReset  out  1  reset to the sub-AFU.
- drain_done  out  1  drain complete, counters zero (or timed out).
- drain_timeout  out  1  sticky: the last drain ended by timeout.
- cnt_err  out  1  sticky: a response arrived while its counter was 0.
- rd_outstanding  out  CNT_W  outstanding read lines.
- wr_outstanding  out  CNT_W  outstanding write lines plus fences.

Behaviour:
- Reset values: state=RUN; all valids on dn_TxPort and afu_RxPort = 0; afu_SoftReset=1; drain_done=0; drain_timeout=0; cnt_err=0; both counters=0.
- Release after SoftReset:
  - afu_SoftReset falls 1 cycle after SoftReset deasserts, provided drain_req=0.
  - If drain_req=1 at that point, the FSM enters DRAIN directly.
- Datapath (registered, latency 1 in both directions):
  - Tx: dn_TxPort <= afu_TxPort. c0.valid and c1.valid are forced to 0 when state≠RUN.
  - c2 (MMIO response) always passes through ungated.
  - Rx: afu_RxPort <= dn_RxPort. c0.rspValid and c1.rspValid are forced to 0 when state≠RUN.
  - Almost-full bits and MMIO request fields always pass through.
- Read counting:
  - +(cl_len+1) per c0 read request accepted into dn_TxPort.
  - −1 per c0 read response line.
- Write counting:
  - +(cl_len+1) per c1 write request with sop=1; +0 for non-sop beats.
  - +1 per write fence.
  - −1 per c1 write response with format=0.
  - −(cl_num+1) per c1 write response with format=1 (packed).
  - −1 per write-fence response.
- Counter arithmetic:
  - Increment and decrement in the same cycle are summed into one net update.
  - Saturating at 0: a decrement larger than the current value sets the counter to 0 and sets cnt_err.
  - Saturating at max: no wrap; set cnt_err.
- States:
  - RUN:
    - afu_SoftReset=0, drain_done=0.
    - drain_req=1 → DRAIN. The Tx request presented in that same cycle is still forwarded and counted.
  - DRAIN:
    - afu_SoftReset=1, Tx gated, Rx responses counted but dropped.
    - Timeout counter runs from 0.
    - Both counters reach 0, evaluated after this cycle's update → DONE.
    - Timeout counter == TIMEOUT_CYCLES−1 → DONE; set drain_timeout; clear both counters.
  - DONE:
    - drain_done=1, afu_SoftReset=1.
    - Late responses are dropped and set cnt_err.
    - drain_req=0 → RUN next cycle.
    - On that RUN entry: afu_SoftReset=0, drain_done=0.
- drain_req deasserting during DRAIN does not abort the drain. The FSM completes DRAIN → DONE, then moves to RUN.
- drain_timeout and cnt_err clear only on SoftReset or on entry to DRAIN.
- SoftReset mid-operation: all state returns to its reset values immediately on the next edge. Outstanding counts are discarded.

Test Plan:
- Reset release, drain_req=0: afu_SoftReset goes 1→0 one cycle after SoftReset falls. A 4-line read (cl_len=3) makes rd_outstanding=4. Four read responses bring it back to 0; each is forwarded with latency 1.
- Issue 2 single-line writes plus 1 fence, then raise drain_req: wr_outstanding=3, afu_SoftReset=1 next cycle. Return 1 packed response with cl_num=1 plus 1 fence response → drain_done=1 one cycle after the last response. No response reaches afu_RxPort.
- drain_req raised in the same cycle as a 2-line read request: the request is forwarded with rd_outstanding=2. Drain waits for 2 responses, and later Tx valids from the AFU are blocked.
- Same cycle as a +1 write request and a −1 write response at wr_outstanding=1: the count stays 1. A response at count 0 sets cnt_err and the count remains 0.
- Drain with 1 read that never returns, TIMEOUT_CYCLES=16: DONE is reached 16 cycles after DRAIN entry, drain_timeout=1, counters=0. A late response sets cnt_err and is not forwarded.
- Assert SoftReset during DRAIN with rd_outstanding=5: next cycle counters=0, state RUN, afu_SoftReset=1, all valids 0.
